// File: rtl/motor_encoder_emulator_if.sv
// Peripheral bus bundle for the motor encoder emulator.
//   din      : write data (master -> slave)
//   address  : register address (master -> slave)
//   w_en     : write strobe, a write lands on the clk edge where it is high
//   r_en     : read strobe, dout reflects the addressed register one clk later
//   dout     : registered read data (slave -> master), holds while r_en is low
// The bus has no valid/ready back-pressure: every strobe is accepted on the
// edge where it is high, so a master never waits on the slave.
interface motor_encoder_emulator_if;
  logic [7:0] din;
  logic [7:0] address;
  logic       w_en;
  logic       r_en;
  logic [7:0] dout;

  modport master (output din, output address, output w_en, output r_en, input dout);
  modport slave  (input din, input address, input w_en, input r_en, output dout);
endinterface

// File: rtl/motor_encoder_emulator.sv
// Emulates two gearmotors with quadrature-less encoders for bring-up without
// a drivetrain. The controller's pwm is sampled into a per-frame duty, a
// first-order lag turns duty into wheel speed, and a phase accumulator turns
// speed into an encoder edge train.
// Ports:
//   clk, rst  : system clock, asynchronous active-high reset
//   bus       : 8-bit register window (CTRL, SPEED_0/1, DUTY_0/1, TAU)
//   pwm[1:0]  : controller pwm, bit i = channel i
//   motor[3:0]: direction, [1:0] = channel 0, [3:2] = channel 1
//   enable    : driver enable
//   encoders  : emulated encoder lines, bit i = channel i
module motor_encoder_emulator #(
  parameter int          F_CPU             = 16000000,
  parameter logic [7:0]  EMULATOR_ADDRESS  = 8'h00,
  parameter int          SAMPLE_DIV        = 126,
  parameter int          MAX_EDGES_PER_SEC = 2278,
  parameter int          ACC_WIDTH         = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  motor_encoder_emulator_if.slave  bus,
  input  logic [1:0]               pwm,
  input  logic [3:0]               motor,
  input  logic                     enable,
  output logic [1:0]               encoders
);

  // Phase increment per unit of speed, rounded to nearest.
  localparam logic [63:0] K_NUM = (64'(MAX_EDGES_PER_SEC) << ACC_WIDTH) + (64'd255 * 64'(F_CPU)) / 64'd2;
  localparam logic [63:0] K_DEN = 64'd255 * 64'(F_CPU);
  localparam logic [ACC_WIDTH-1:0] K = ACC_WIDTH'(K_NUM / K_DEN);

  localparam int DIV_W = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

  logic             run_q;
  logic [2:0]       tau_q;
  logic [DIV_W-1:0] div_q;
  logic [7:0]       frame_q;
  logic [7:0]       dout_q;
  logic [7:0]       rd_data;
  logic [7:0]       offset;
  logic             tick;
  logic             frame_end;
  logic [7:0]       speed_w [2];
  logic [7:0]       duty_w  [2];

  assign offset    = bus.address - EMULATOR_ADDRESS;
  assign tick      = (div_q == DIV_LAST);
  assign frame_end = tick && (frame_q == 8'hFF);
  assign bus.dout  = dout_q;

  always_comb begin
    rd_data = 8'd0;
    case (offset)
      8'd0:    rd_data = {7'd0, run_q};
      8'd1:    rd_data = speed_w[0];
      8'd2:    rd_data = speed_w[1];
      8'd3:    rd_data = duty_w[0];
      8'd4:    rd_data = duty_w[1];
      8'd5:    rd_data = {5'd0, tau_q};
      default: rd_data = 8'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q   <= 1'b1;
      tau_q   <= 3'd3;
      div_q   <= '0;
      frame_q <= 8'd0;
      dout_q  <= 8'd0;
    end else begin
      if (bus.w_en && offset == 8'd0) run_q <= bus.din[0];
      if (bus.w_en && offset == 8'd5) tau_q <= bus.din[2:0];
      if (bus.r_en) dout_q <= rd_data;
      // Stopping discards the partial frame: counting restarts at 0 on run.
      if (!run_q) begin
        div_q   <= '0;
        frame_q <= 8'd0;
      end else begin
        div_q <= tick ? '0 : div_q + 1'b1;
        if (tick) frame_q <= frame_q + 8'd1;
      end
    end
  end

  for (genvar c = 0; c < 2; c++) begin : g_ch
    logic [7:0]           duty_q;
    logic [7:0]           speed_q;
    logic [8:0]           hi_q;
    logic [ACC_WIDTH-1:0] acc_q;
    logic                 enc_q;

    logic [1:0]           dir;
    logic                 driven;
    logic [8:0]           hi_inc;
    logic [7:0]           duty_new;
    logic [7:0]           target;
    logic signed [8:0]    diff;
    logic signed [8:0]    shifted;
    logic signed [8:0]    step;
    logic signed [9:0]    nxt;
    logic [7:0]           speed_new;
    logic [ACC_WIDTH-1:0] inc;
    logic [ACC_WIDTH:0]   acc_sum;

    assign dir      = motor[2*c +: 2];
    assign driven   = enable & run_q & ((dir == 2'b01) || (dir == 2'b10));
    // The closing tick's own sample is included before the duty is latched.
    assign hi_inc   = hi_q + {8'd0, pwm[c]};
    assign duty_new = hi_inc[8] ? 8'hFF : hi_inc[7:0];
    assign target   = driven ? duty_new : 8'd0;
    assign diff     = $signed({1'b0, target}) - $signed({1'b0, speed_q});
    assign shifted  = diff >>> tau_q;
    // A minimum step of one keeps small errors from stalling short of target.
    assign step     = (diff != 9'sd0 && shifted == 9'sd0) ? (diff[8] ? -9'sd1 : 9'sd1) : shifted;
    assign nxt      = $signed({2'b00, speed_q}) + $signed({step[8], step});
    assign speed_new = nxt[9] ? 8'd0 : (nxt[8] ? 8'hFF : nxt[7:0]);
    assign inc      = ACC_WIDTH'(speed_q) * K;
    assign acc_sum  = {1'b0, acc_q} + {1'b0, inc};

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        duty_q  <= 8'd0;
        speed_q <= 8'd0;
        hi_q    <= 9'd0;
        acc_q   <= '0;
        enc_q   <= 1'b0;
      end else if (!run_q) begin
        // Duty and encoder level are left as they were.
        speed_q <= 8'd0;
        hi_q    <= 9'd0;
        acc_q   <= '0;
      end else begin
        acc_q <= acc_sum[ACC_WIDTH-1:0];
        if (acc_sum[ACC_WIDTH]) enc_q <= ~enc_q;
        if (frame_end) begin
          duty_q  <= duty_new;
          hi_q    <= 9'd0;
          speed_q <= speed_new;
        end else if (tick) begin
          hi_q <= hi_inc;
        end
      end
    end

    assign speed_w[c]  = speed_q;
    assign duty_w[c]   = duty_q;
    assign encoders[c] = enc_q;
  end

endmodule
